nibble_serial_adder: RTL and testbench



---
 rtl/nibble_adder_pkg.sv | 17 +
 rtl/nibble_serial_adder_adder4.sv | 35 +++
 rtl/nibble_serial_adder.sv | 153 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the slice width, FSM state type and nibble-count helper.
package nibble_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int nib_of(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_adder4.sv
// Combinational 4-bit ripple-carry slice.
// With NIBBLE_SERIAL_ADDER_OVF_EN it also exposes c3, the carry into bit 3.
module adder4
    import nibble_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] c,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic             c3,
`endif
    output logic             cout
);

    logic [NIB_W:0] cy;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        c     = '0;
        cy    = '0;
        cy[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            c[i]    = a[i] ^ b[i] ^ cy[i];
            cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = cy[NIB_W];

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign c3 = cy[NIB_W-1];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock through one 4-bit slice.
// Optional signed-overflow output: define NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NIB   = nib_of(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_e state_q, state_d;

    logic [NIB-1:0][NIB_W-1:0] a_q, a_d;
    logic [NIB-1:0][NIB_W-1:0] b_q, b_d;
    logic [NIB-1:0][NIB_W-1:0] sum_q, sum_d;

    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [NIB_W-1:0] s_a;
    logic [NIB_W-1:0] s_b;
    logic [NIB_W-1:0] s_sum;
    logic             s_cout;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             s_c3;
    logic             ovf_q, ovf_d;
`endif

    assign s_a = a_q[idx_q];
    assign s_b = b_q[idx_q];

    adder4 u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry_q),
        .c    (s_sum),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        .c3   (s_c3),
`endif
        .cout (s_cout)
    );

    // Next-state logic: accept, one nibble per RUN cycle, hold in DONE.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ovf_d       = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = cin;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = s_sum;
                carry_d      = s_cout;
                if (idx_q == IDX_LAST) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    ovf_d       = s_c3 ^ s_cout;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = carry_q;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to also check ovf.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic        iv16, ir16, ov16, or16, c16, co16;
    logic [15:0] a16, b16, s16;
    logic        iv4, ir4, ov4, or4, c4, co4;
    logic [3:0]  a4, b4, s4;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic        ovf16, ovf4;
`endif

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .a         (a16),
        .b         (b16),
        .cin       (c16),
        .out_valid (ov16),
        .out_ready (or16),
        .sum       (s16),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        .ovf       (ovf16),
`endif
        .cout      (co16)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .a         (a4),
        .b         (b4),
        .cin       (c4),
        .out_valid (ov4),
        .out_ready (or4),
        .sum       (s4),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        .ovf       (ovf4),
`endif
        .cout      (co4)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int          acc_q[$];
    logic [16:0] res_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (resetn && iv16 && ir16) acc_q.push_back(cyc);
        if (resetn && ov16 && or16) res_q.push_back({co16, s16});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] es,
                        input logic eco, input string tag);
        int lat;
        iv16 = 1'b1;
        a16  = a;
        b16  = b;
        c16  = c;
        or16 = 1'b1;
        tick;
        iv16 = 1'b0;
        a16  = 16'hDEAD;
        b16  = 16'hBEEF;
        c16  = 1'b1;
        lat  = 0;
        while (!ov16 && lat < 20) begin
            tick;
            lat++;
        end
        chk({tag, " lat"}, lat, 4);
        chk({tag, " sum"}, s16, es);
        chk({tag, " cout"}, co16, eco);
        tick;
        chk({tag, " rdy"}, ir16, 1);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input logic c, input string tag);
        int lat;
        logic [4:0] e;
        e   = {1'b0, a} + {1'b0, b} + {4'b0, c};
        iv4 = 1'b1;
        a4  = a;
        b4  = b;
        c4  = c;
        tick;
        iv4 = 1'b0;
        a4  = ~a;
        b4  = ~b;
        c4  = ~c;
        lat = 0;
        while (!ov4 && lat < 10) begin
            tick;
            lat++;
        end
        chk({tag, " lat"}, lat, 1);
        chk({tag, " sum"}, s4, e[3:0]);
        chk({tag, " cout"}, co4, e[4]);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        chk({tag, " ovf"}, ovf4,
            (a[3] == b[3]) && (e[3] != a[3]));
`endif
        tick;
    endtask

    initial begin
        int t;
        logic [16:0] r0, r1;
        int ac0, ac1;

        resetn = 1'b0;
        iv16 = 0; or16 = 0; a16 = 0; b16 = 0; c16 = 0;
        iv4  = 0; or4  = 1; a4  = 0; b4  = 0; c4  = 0;
        tick;
        tick;
        resetn = 1'b1;

        chk("rst rdy", ir16, 1);
        chk("rst vld", ov16, 0);
        chk("rst sum", s16, 0);
        chk("rst cout", co16, 0);
        chk("rst4 rdy", ir4, 1);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        chk("rst ovf", ovf16, 0);
`endif

        // Reset two cycles into RUN
        iv16 = 1'b1;
        a16  = 16'h1234;
        b16  = 16'h1111;
        c16  = 1'b0;
        tick;
        iv16 = 1'b0;
        tick;
        tick;
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        chk("abort vld", ov16, 0);
        chk("abort rdy", ir16, 1);
        chk("abort sum", s16, 0);
        op16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "post");

        op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "chain");
        op16(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, "cin");
        op16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, "mix");

        // Back-pressure
        or16 = 1'b0;
        iv16 = 1'b1;
        a16  = 16'h8000;
        b16  = 16'h8000;
        c16  = 1'b0;
        tick;
        iv16 = 1'b0;
        t = 0;
        while (!ov16 && t < 20) begin
            tick;
            t++;
        end
        chk("bp lat", t, 4);
        for (int i = 0; i < 10; i++) begin
            chk("bp vld", ov16, 1);
            chk("bp sum", s16, 0);
            chk("bp cout", co16, 1);
            chk("bp rdy", ir16, 0);
            tick;
        end
        or16 = 1'b1;
        tick;
        or16 = 1'b0;
        chk("bp idle rdy", ir16, 1);
        chk("bp idle vld", ov16, 0);

        // Back-to-back with in_valid held high
        acc_q.delete();
        res_q.delete();
        or16 = 1'b1;
        iv16 = 1'b1;
        a16  = 16'h00FF;
        b16  = 16'h0F0F;
        c16  = 1'b0;
        t = 0;
        while (res_q.size() < 2 && t < 40) begin
            tick;
            t++;
            if (acc_q.size() == 1) begin
                a16 = 16'hAAAA;
                b16 = 16'h5555;
                c16 = 1'b1;
            end
            if (acc_q.size() >= 2) iv16 = 1'b0;
        end
        iv16 = 1'b0;
        r0  = (res_q.size() > 0) ? res_q[0] : 'x;
        r1  = (res_q.size() > 1) ? res_q[1] : 'x;
        ac0 = (acc_q.size() > 0) ? acc_q[0] : 0;
        ac1 = (acc_q.size() > 1) ? acc_q[1] : 0;
        chk("b2b n", res_q.size(), 2);
        chk("b2b r0", r0, 17'h0100E);
        chk("b2b r1", r1, 17'h10000);
        chk("b2b gap", ac1 - ac0, 6);
        tick;
        tick;

        // Exhaustive WIDTH=4
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            op4(v[3:0], v[7:4], v[8], $sformatf("w4 %0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
